// File: rtl/mul_hilo_ctrl.sv
// mul_hilo_ctrl: sequencing and HI/LO result stage around a shift-add multiplier.
// Decodes the ALU function code, launches MULTU operations, waits MUL_CYCLES
// multiplier steps, captures the 64-bit product into HI/LO and serves
// MFHI/MFLO reads, stalling recognised requests while a multiply is in flight.
// Optional feature: define MUL_HILO_MTHILO_EN to decode MTHI/MTLO writes.
module mul_hilo_ctrl #(
    parameter int unsigned MUL_CYCLES = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid,
    input  logic [5:0]  Signal,
    input  logic [31:0] dataA,
    input  logic [31:0] dataB,
    input  logic [63:0] product,
    output logic [31:0] mulA,
    output logic [31:0] mulB,
    output logic        mulStart,
    output logic        busy,
    output logic        stall,
    output logic [31:0] dataOut,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    // Iteration counter sized to hold 0..MUL_CYCLES-1
    localparam int unsigned CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // ALU function codes
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
`ifdef MUL_HILO_MTHILO_EN
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MTLO  = 6'b010011;
`endif

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_START   = 2'd1,
        S_RUN     = 2'd2,
        S_CAPTURE = 2'd3
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [31:0]        r_mul_a;
    logic [31:0]        r_mul_b;
    logic               r_mul_start;
    logic               r_busy;
    logic [31:0]        r_data_out;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;

    logic               w_is_multu;
    logic               w_is_mfhi;
    logic               w_is_mflo;
    logic               w_is_mthi;
    logic               w_is_mtlo;
    logic               w_known;
    logic               w_stall;

    // Function-code decode; move-to codes only exist when the feature is built in
    always_comb begin
        w_is_multu = (Signal == FN_MULTU);
        w_is_mfhi  = (Signal == FN_MFHI);
        w_is_mflo  = (Signal == FN_MFLO);
        w_is_mthi  = 1'b0;
        w_is_mtlo  = 1'b0;
`ifdef MUL_HILO_MTHILO_EN
        w_is_mthi  = (Signal == FN_MTHI);
        w_is_mtlo  = (Signal == FN_MTLO);
`endif
        w_known    = w_is_multu | w_is_mfhi | w_is_mflo | w_is_mthi | w_is_mtlo;
    end

    // Recognised request that cannot be taken because a multiply is in flight
    always_comb begin
        w_stall = valid & r_busy & w_known & ~reset;
    end

    // Control FSM with registered outputs and HI/LO/result holding registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_mul_a     <= '0;
            r_mul_b     <= '0;
            r_mul_start <= 1'b0;
            r_busy      <= 1'b0;
            r_data_out  <= '0;
            r_hi        <= '0;
            r_lo        <= '0;
        end else begin
            r_mul_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (valid) begin
                        if (w_is_multu) begin
                            r_mul_a     <= dataA;
                            r_mul_b     <= dataB;
                            r_mul_start <= 1'b1;
                            r_busy      <= 1'b1;
                            r_state     <= S_START;
                        end else if (w_is_mfhi) begin
                            r_data_out  <= r_hi;
                        end else if (w_is_mflo) begin
                            r_data_out  <= r_lo;
                        end else if (w_is_mthi) begin
                            r_hi        <= dataA;
                        end else if (w_is_mtlo) begin
                            r_lo        <= dataA;
                        end
                    end
                end
                S_START: begin
                    r_cnt   <= '0;
                    r_state <= S_RUN;
                end
                S_RUN: begin
                    r_cnt <= r_cnt + CNT_ONE;
                    if (r_cnt == CNT_LAST) begin
                        r_state <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    r_hi    <= product[63:32];
                    r_lo    <= product[31:0];
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign mulA     = r_mul_a;
    assign mulB     = r_mul_b;
    assign mulStart = r_mul_start;
    assign busy     = r_busy;
    assign stall    = w_stall;
    assign dataOut  = r_data_out;
    assign hi       = r_hi;
    assign lo       = r_lo;

endmodule

// File: tb/tb_mul_hilo_ctrl.sv
// Bench for mul_hilo_ctrl: behavioural multiplier, cycle-level reference model,
// table of MULTU vectors, directed corner sequences and random traffic.
// Build with MUL_HILO_MTHILO_EN defined to exercise MTHI/MTLO.
module tb_mul_hilo_ctrl;

    localparam int unsigned M = 32;

    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MTLO  = 6'b010011;
    localparam logic [5:0] FN_BAD   = 6'b100000;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid;
    logic [5:0]  Signal;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic [63:0] product;
    logic [31:0] mulA;
    logic [31:0] mulB;
    logic        mulStart;
    logic        busy;
    logic        stall;
    logic [31:0] dataOut;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    mul_hilo_ctrl #(.MUL_CYCLES(M)) dut (
        .clk      (clk),
        .reset    (reset),
        .valid    (valid),
        .Signal   (Signal),
        .dataA    (dataA),
        .dataB    (dataB),
        .product  (product),
        .mulA     (mulA),
        .mulB     (mulB),
        .mulStart (mulStart),
        .busy     (busy),
        .stall    (stall),
        .dataOut  (dataOut),
        .hi       (hi),
        .lo       (lo)
    );

    // Behavioural shift-add stand-in: garbage until M negedge steps after start
    int unsigned mstep = M;
    initial product = 64'd0;
    always @(negedge clk) begin
        if (mulStart) begin
            mstep   <= 0;
            product <= 64'hBAD0_BAD0_BAD0_BAD0;
        end else if (mstep < M) begin
            mstep <= mstep + 1;
            if (mstep + 1 == M) product <= {32'd0, mulA} * {32'd0, mulB};
        end
    end

    // Reference model state
    logic [31:0] m_hi, m_lo, m_dout, m_a, m_b;
    bit          m_start;
    int          m_left;   // cycles of busy remaining; product lands when it reaches 0

    function automatic bit is_known(input logic [5:0] s);
        bit k;
        k = (s == FN_MULTU) || (s == FN_MFHI) || (s == FN_MFLO);
`ifdef MUL_HILO_MTHILO_EN
        k = k || (s == FN_MTHI) || (s == FN_MTLO);
`endif
        return k;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive, check stall, advance model, check registered outputs
    task automatic step(input bit r, input bit v, input logic [5:0] s,
                        input logic [31:0] a, input logic [31:0] b);
        bit start_n;
        reset = r; valid = v; Signal = s; dataA = a; dataB = b;
        #1;
        check("stall", 64'(stall), 64'(!r && v && (m_left > 0) && is_known(s)));
        start_n = 1'b0;
        if (r) begin
            m_hi = 0; m_lo = 0; m_dout = 0; m_a = 0; m_b = 0; m_left = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) {m_hi, m_lo} = {32'd0, m_a} * {32'd0, m_b};
        end else if (v) begin
            if (s == FN_MULTU) begin
                m_a = a; m_b = b; m_left = M + 2; start_n = 1'b1;
            end else if (s == FN_MFHI) m_dout = m_hi;
            else if (s == FN_MFLO) m_dout = m_lo;
`ifdef MUL_HILO_MTHILO_EN
            else if (s == FN_MTHI) m_hi = a;
            else if (s == FN_MTLO) m_lo = a;
`endif
        end
        m_start = start_n;
        @(posedge clk);
        #1;
        cyc++;
        check("busy",     64'(busy),     64'(m_left > 0));
        check("mulStart", 64'(mulStart), 64'(m_start));
        check("hi",       64'(hi),       64'(m_hi));
        check("lo",       64'(lo),       64'(m_lo));
        check("dataOut",  64'(dataOut),  64'(m_dout));
        check("mulA",     64'(mulA),     64'(m_a));
        check("mulB",     64'(mulB),     64'(m_b));
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 6'd0, 32'd0, 32'd0);
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int busy_n, start_n, guard, stalls;
        logic [5:0] codes[6];

        tbl[0] = '{32'd3,          32'd5,          32'h0000_0000, 32'h0000_000F};
        tbl[1] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE, 32'h0000_0001};
        tbl[2] = '{32'h0001_0000,  32'h0001_0000,  32'h0000_0001, 32'h0000_0000};
        tbl[3] = '{32'h8000_0000,  32'd2,          32'h0000_0001, 32'h0000_0000};
        tbl[4] = '{32'd0,          32'hDEAD_BEEF,  32'h0000_0000, 32'h0000_0000};
        tbl[5] = '{32'h1234_5678,  32'h0000_0100,  32'h0000_0012, 32'h3456_7800};

        codes[0] = FN_MULTU; codes[1] = FN_MFHI; codes[2] = FN_MFLO;
        codes[3] = FN_MTHI;  codes[4] = FN_MTLO; codes[5] = FN_BAD;

        m_hi = 0; m_lo = 0; m_dout = 0; m_a = 0; m_b = 0; m_left = 0; m_start = 0;

        // Reset, with a request presented that must be ignored
        step(1'b1, 1'b1, FN_MULTU, 32'h55, 32'h66);
        step(1'b1, 1'b0, 6'd0, 32'd0, 32'd0);

        // Table of multiplies: latency, start pulse, product and MF reads
        foreach (tbl[i]) begin
            step(1'b0, 1'b1, FN_MULTU, tbl[i].a, tbl[i].b);
            busy_n = 0; start_n = 0; guard = 0;
            while (busy && guard < 200) begin
                busy_n++;
                if (mulStart) start_n++;
                idle();
                guard++;
            end
            check("busy_cycles", 64'(busy_n), 64'(M + 2));
            check("start_pulses", 64'(start_n), 64'd1);
            check("tbl_hi", 64'(hi), 64'(tbl[i].exp_hi));
            check("tbl_lo", 64'(lo), 64'(tbl[i].exp_lo));
            step(1'b0, 1'b1, FN_MFLO, 32'd0, 32'd0);
            check("tbl_mflo", 64'(dataOut), 64'(tbl[i].exp_lo));
            step(1'b0, 1'b1, FN_MFHI, 32'd0, 32'd0);
            check("tbl_mfhi", 64'(dataOut), 64'(tbl[i].exp_hi));
        end

        // MFHI held from T+5: stalls through CAPTURE, returns the new HI
        step(1'b0, 1'b1, FN_MULTU, 32'hFFFF_FFFF, 32'd2);
        repeat (4) idle();
        stalls = 0; guard = 0;
        while (m_left > 0 && guard < 200) begin
            stalls++;
            step(1'b0, 1'b1, FN_MFHI, 32'd0, 32'd0);
            guard++;
        end
        step(1'b0, 1'b1, FN_MFHI, 32'd0, 32'd0);
        check("mfhi_stalls", 64'(stalls), 64'(M - 2));
        check("mfhi_new", 64'(dataOut), 64'h1);
        step(1'b0, 1'b1, FN_MFLO, 32'd0, 32'd0);
        check("mflo_b2b", 64'(dataOut), 64'hFFFF_FFFE);

        // MULTU held through a multiply is taken the cycle busy falls
        step(1'b0, 1'b1, FN_MULTU, 32'd10, 32'd10);
        guard = 0;
        while (m_left > 0 && guard < 200) begin
            step(1'b0, 1'b1, FN_MULTU, 32'd7, 32'd6);
            guard++;
        end
        step(1'b0, 1'b1, FN_MULTU, 32'd7, 32'd6);
        check("b2b_mulA", 64'(mulA), 64'd7);
        check("b2b_busy", 64'(busy), 64'd1);
        check("b2b_hilo", {32'(hi), 32'(lo)}, 64'd100);

        // Unknown code during RUN is ignored and leaves operands alone
        repeat (5) idle();
        step(1'b0, 1'b1, FN_BAD, 32'hAAAA_AAAA, 32'hBBBB_BBBB);
        check("bad_mulA", 64'(mulA), 64'd7);
        check("bad_mulB", 64'(mulB), 64'd6);
        guard = 0;
        while (busy && guard < 200) begin idle(); guard++; end
        check("b2b_lo", 64'(lo), 64'd42);

        // Reset at T+20 of a multiply discards it
        step(1'b0, 1'b1, FN_MULTU, 32'h0001_0000, 32'h0003_0000);
        repeat (19) idle();
        step(1'b1, 1'b0, 6'd0, 32'd0, 32'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_hilo", {32'(hi), 32'(lo)}, 64'd0);
        repeat (M + 5) idle();
        check("rst_nocap", {32'(hi), 32'(lo)}, 64'd0);

        // Move-to-HI: written when built in, otherwise ignored
        step(1'b0, 1'b1, FN_MTHI, 32'h1234_5678, 32'd0);
        step(1'b0, 1'b1, FN_MFHI, 32'd0, 32'd0);
`ifdef MUL_HILO_MTHILO_EN
        check("mthi_mfhi", 64'(dataOut), 64'h1234_5678);
`else
        check("mthi_off", 64'(hi), 64'd0);
`endif

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            bit r, v;
            logic [5:0] s;
            r = ($urandom_range(0, 199) == 0);
            v = ($urandom_range(0, 9) < 7);
            s = codes[$urandom_range(0, 5)];
            step(r, v, s, $urandom, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_hilo_ctrl.md
# mul_hilo_ctrl

Sequencing and result-holding stage wrapped around the shift-add multiplier. Decodes the ALU function code and latches operands on MULTU. Pulses the multiplier's start input and counts its iterations. Captures the 64-bit product into HI/LO and returns HI or LO on MFHI/MFLO, stalling the pipeline while a multiply is in flight.

## Interface
- `MUL_CYCLES`, default 32: multiplier iterations (negedge steps) to wait before capture.
- `clk` in 1: clock; all state changes on rising edge.
- `reset` in 1: synchronous, active-high.
- `valid` in 1: a request is presented this cycle.
- `Signal` in 6: function code. MULTU=6'b011001, MFHI=6'b010000, MFLO=6'b010010, MTHI=6'b010001, MTLO=6'b010011.
- `dataA` in 32: multiplicand / MTHI/MTLO source.
- `dataB` in 32: multiplier operand.
- `product` in 64: multiplier result bus, `{hi,lo}`.
- `mulA` out 32: latched multiplicand, drives the multiplier.
- `mulB` out 32: latched multiplier operand.
- `mulStart` out 1: one-cycle start pulse to the multiplier.
- `busy` out 1: multiply in flight.
- `stall` out 1: request presented but not accepted this cycle; combinational.
- `dataOut` out 32: registered MFHI/MFLO result.
- `hi` out 32: HI register.
- `lo` out 32: LO register.

## Operation
- States:
  - IDLE: accept requests.
  - START: `mulStart`=1 for exactly this cycle.
  - RUN: counter `cnt` 0..MUL_CYCLES-1.
  - CAPTURE: `{hi,lo}` <= `product`.
- IDLE, `valid` & MULTU:
  - `mulA`<=`dataA`, `mulB`<=`dataB`.
  - Next state START.
- START -> RUN; `cnt`<=0.
- RUN:
  - `cnt`++ each cycle.
  - At `cnt`==MUL_CYCLES-1 -> CAPTURE.
- CAPTURE -> IDLE unconditionally.
- IDLE, `valid` & MFHI: `dataOut`<=`hi`. MFLO: `dataOut`<=`lo`. Stay IDLE.
- `busy` = state != IDLE.
- `stall` = `valid` & `busy` & (Signal is MULTU/MFHI/MFLO, or MTHI/MTLO when enabled).
  - A stalled request produces no state change.
  - Upstream holds `Signal`/`dataA`/`dataB` until `stall` drops; the request is then accepted in that IDLE cycle.
- Unrecognised codes: ignored, never stall, no state change.
- `mulA`/`mulB` stay constant from acceptance until the next accepted MULTU.
- `dataOut` holds its last value when no MF* is accepted.
- Reset values:
  - State IDLE, `cnt`=0.
  - `hi`=`lo`=`dataOut`=`mulA`=`mulB`=0.
  - `mulStart`=0, `busy`=0, `stall`=0.
- Reset mid-operation, in any state including CAPTURE:
  - Returns to IDLE with reset values.
  - In-flight product is discarded; HI/LO are not written.
- `valid` with reset high: ignored.

## Timing
- MULTU accepted at cycle T:
  - `mulStart` high during T+1 only.
  - RUN spans T+2 .. T+1+MUL_CYCLES.
  - CAPTURE at T+2+MUL_CYCLES.
  - `hi`/`lo` show the new product from T+3+MUL_CYCLES, when `busy` is low.
- Total MULTU latency is MUL_CYCLES+3 cycles from acceptance to HI/LO visible (35 at default).
- MFHI/MFLO accepted at T: `dataOut` valid at T+1.
- Back-to-back MFHI then MFLO: one result per cycle, no bubble.
- MF* issued during CAPTURE: stalled one cycle, accepted in the following IDLE cycle, and returns the new product.
- MULTU issued in the cycle `busy` falls: accepted that cycle; no dead cycle.

## Configuration
- `MUL_HILO_MTHILO_EN` defined:
  - MTHI/MTLO decoded. In IDLE, `valid` & MTHI: `hi`<=`dataA`; MTLO: `lo`<=`dataA`.
  - Both stall while `busy`, like other ops.
  - Result visible in `hi`/`lo` the next cycle.
- Not defined: codes 6'b010001/6'b010011 are unrecognised, so they are ignored and never stall.

## Test plan
- Reset, then MULTU with `dataA`=3, `dataB`=5, with the multiplier attached:
  - `mulStart` pulses at T+1.
  - `busy` high for 34 cycles.
  - `hi`=0, `lo`=15 at T+35.
  - MFLO then MFHI -> `dataOut`=15, then 0.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> `hi`=0xFFFFFFFE, `lo`=0x00000001.
- MFHI held valid from T+5 during a multiply -> `stall`=1 until the IDLE cycle; `dataOut` returns the new `hi` one cycle after acceptance.
- Reset asserted at T+20 of a multiply:
  - `busy`=0 and `hi`=`lo`=0 the next cycle.
  - No capture happens afterwards.
- Unknown code 6'b100000 with `valid`=1 during RUN: `stall`=0, no state change, `mulA`/`mulB` unchanged.
- With `MUL_HILO_MTHILO_EN`: MTHI `dataA`=0x12345678 then MFHI -> `dataOut`=0x12345678. Without it: `hi` stays 0.
